// File: rtl/secuencia_ctrl.sv
// Test sequencer for a serial sequence detector: shifts a test word into det_w, counts z rises.
// Optional SEC_CTRL_LOOP_EN: one-cycle DONE pulse, result register, auto-rerun while start held.
module secuencia_ctrl #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIV   = 1,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    output logic             det_rst,
    output logic             det_w,
    input  logic             det_z,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count
);

    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StResetDut = 3'd1;
    localparam logic [2:0] StShift    = 3'd2;
    localparam logic [2:0] StDrain    = 3'd3;
    localparam logic [2:0] StDone     = 3'd4;

    localparam int unsigned BitW = $clog2(WIDTH);
    localparam int unsigned DivW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [BitW-1:0]  BitLast = BitW'(WIDTH - 1);
    localparam logic [DivW-1:0]  DivLast = DivW'(DIV - 1);
    localparam logic [CNT_W-1:0] CntMax  = '1;

    logic [2:0]       state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [BitW-1:0]  bit_q, bit_d;
    logic [DivW-1:0]  div_q, div_d;
    logic             phase_q, phase_d;
    logic             z_prev_q, z_prev_d;
    logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
    logic             accept;
    logic             counting;

`ifdef SEC_CTRL_LOOP_EN
    logic [CNT_W-1:0] res_q, res_d;
`endif

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        bit_d     = bit_q;
        div_d     = div_q;
        phase_d   = phase_q;
        z_prev_d  = det_z;
        run_cnt_d = run_cnt_q;
        accept    = 1'b0;
        counting  = (state_q == StShift) || (state_q == StDrain);

        // Edge-detect z so a level held for several cycles counts once.
        if (counting && det_z && !z_prev_q && (run_cnt_q != CntMax)) begin
            run_cnt_d = run_cnt_q + 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (start) accept = 1'b1;
            end
            StResetDut: begin
                z_prev_d = 1'b0;
                phase_d  = ~phase_q;
                if (phase_q) begin
                    state_d = StShift;
                    phase_d = 1'b0;
                end
            end
            StShift: begin
                if (div_q == DivLast) begin
                    div_d = '0;
                    sr_d  = {sr_q[WIDTH-2:0], 1'b0};
                    bit_d = bit_q + 1'b1;
                    if (bit_q == BitLast) begin
                        state_d = StDrain;
                        bit_d   = '0;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            StDrain: begin
                phase_d = ~phase_q;
                if (phase_q) begin
                    state_d = StDone;
                    phase_d = 1'b0;
                end
            end
            StDone: begin
                if (start) begin
                    accept = 1'b1;
                end
`ifdef SEC_CTRL_LOOP_EN
                else begin
                    state_d = StIdle;
                end
`endif
            end
            default: state_d = StIdle;
        endcase

        if (accept) begin
            state_d   = StResetDut;
            sr_d      = pattern;
            bit_d     = '0;
            div_d     = '0;
            phase_d   = 1'b0;
            run_cnt_d = '0;
        end
    end

`ifdef SEC_CTRL_LOOP_EN
    // Result register publishes the run total as DONE is entered.
    always_comb begin
        res_d = res_q;
        if ((state_q == StDrain) && phase_q) res_d = run_cnt_d;
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StIdle;
            sr_q      <= '0;
            bit_q     <= '0;
            div_q     <= '0;
            phase_q   <= 1'b0;
            z_prev_q  <= 1'b0;
            run_cnt_q <= '0;
`ifdef SEC_CTRL_LOOP_EN
            res_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            bit_q     <= bit_d;
            div_q     <= div_d;
            phase_q   <= phase_d;
            z_prev_q  <= z_prev_d;
            run_cnt_q <= run_cnt_d;
`ifdef SEC_CTRL_LOOP_EN
            res_q     <= res_d;
`endif
        end
    end

    always_comb begin
        det_rst = (state_q == StIdle) || (state_q == StResetDut);
        det_w   = (state_q == StShift) && sr_q[WIDTH-1];
        busy    = (state_q == StResetDut) || (state_q == StShift) || (state_q == StDrain);
        done    = (state_q == StDone);
`ifdef SEC_CTRL_LOOP_EN
        count   = res_q;
`else
        count   = run_cnt_q;
`endif
    end

endmodule

// File: tb/tb_secuencia_ctrl.sv
// Bench for secuencia_ctrl: three instances (DIV=1, DIV=3, CNT_W=2) each driving a Moore "11" detector.
module tb_secuencia_ctrl;

    localparam int N = 3;
    localparam logic [15:0] P1 = 16'b0110111000000011;
    localparam logic [15:0] P2 = 16'b1101101101101101;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] pattern = '0;
    logic [15:0] pattern_c = '0;
    logic [N-1:0] det_rst, det_w, det_z, busy, done;
    logic [4:0]  count_a, count_b;
    logic [1:0]  count_c;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    secuencia_ctrl #(.WIDTH(16), .DIV(1), .CNT_W(5)) u_a (
        .clk(clk), .reset(reset), .start(start), .pattern(pattern),
        .det_rst(det_rst[0]), .det_w(det_w[0]), .det_z(det_z[0]),
        .busy(busy[0]), .done(done[0]), .count(count_a)
    );
    secuencia_ctrl #(.WIDTH(16), .DIV(3), .CNT_W(5)) u_b (
        .clk(clk), .reset(reset), .start(start), .pattern(pattern),
        .det_rst(det_rst[1]), .det_w(det_w[1]), .det_z(det_z[1]),
        .busy(busy[1]), .done(done[1]), .count(count_b)
    );
    secuencia_ctrl #(.WIDTH(16), .DIV(1), .CNT_W(2)) u_c (
        .clk(clk), .reset(reset), .start(start), .pattern(pattern_c),
        .det_rst(det_rst[2]), .det_w(det_w[2]), .det_z(det_z[2]),
        .busy(busy[2]), .done(done[2]), .count(count_c)
    );

    // Moore "11" detector per instance: 0 = none, 1 = one 1 seen, 2 = two or more 1s (z high).
    logic [1:0] ds [N] = '{2'd0, 2'd0, 2'd0};
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (det_rst[i]) ds[i] <= 2'd0;
            else if (det_w[i]) ds[i] <= (ds[i] == 2'd0) ? 2'd1 : 2'd2;
            else ds[i] <= 2'd0;
        end
    end
    always_comb begin
        det_z = '0;
        for (int i = 0; i < N; i++) det_z[i] = (ds[i] == 2'd2);
    end

    // Run model: t = cycles since the accepting edge; outputs follow from where t falls.
    int          divs [N] = '{1, 3, 1};
    int          maxc [N] = '{31, 31, 3};
    bit          run  [N];
    int          t    [N];
    logic [15:0] mpat [N];
    int          mcnt [N];
    bit          zp   [N];

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            int wd;
            wd = 16 * divs[i];
            if (!reset) begin
                run[i] = 1'b0; t[i] = 0; mcnt[i] = 0; zp[i] = 1'b0;
            end else if (start && (!run[i] || t[i] >= wd + 4)) begin
                run[i] = 1'b1; t[i] = 0; mcnt[i] = 0; zp[i] = 1'b0;
                mpat[i] = (i == 2) ? pattern_c : pattern;
            end else if (run[i]) begin
                if (t[i] >= 2 && t[i] < wd + 4 && det_z[i] && !zp[i] && mcnt[i] < maxc[i])
                    mcnt[i]++;
                zp[i] = (t[i] >= 2) ? det_z[i] : 1'b0;
                if (t[i] < 100000) t[i]++;
            end
        end
    end

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] at %0t: got %0d, expected %0d", name, idx, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] cnt_of(input int i);
        if (i == 0) return {27'd0, count_a};
        if (i == 1) return {27'd0, count_b};
        return {30'd0, count_c};
    endfunction

    logic [15:0] cap_a = '0;

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < N; i++) begin
                int wd;
                logic e_rst, e_w, e_busy, e_done;
                wd = 16 * divs[i];
                e_rst = 1'b0; e_w = 1'b0; e_busy = 1'b0; e_done = 1'b0;
                if (!run[i]) begin
                    e_rst = 1'b1;
                end else if (t[i] < 2) begin
                    e_rst = 1'b1; e_busy = 1'b1;
                end else if (t[i] < wd + 2) begin
                    e_w = mpat[i][15 - (t[i] - 2) / divs[i]]; e_busy = 1'b1;
                end else if (t[i] < wd + 4) begin
                    e_busy = 1'b1;
                end else begin
                    e_done = 1'b1;
                end
                check("det_rst", i, {31'd0, det_rst[i]}, {31'd0, e_rst});
                check("det_w",   i, {31'd0, det_w[i]},   {31'd0, e_w});
                check("busy",    i, {31'd0, busy[i]},    {31'd0, e_busy});
                check("done",    i, {31'd0, done[i]},    {31'd0, e_done});
                check("count",   i, cnt_of(i), mcnt[i]);
                if (i == 0 && run[0] && t[0] >= 2 && t[0] < 18) cap_a = {cap_a[14:0], det_w[0]};
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("rst_count", 0, cnt_of(0), 0);
        check("rst_det_rst", 0, {29'd0, det_rst}, 7);
        check("rst_busy_done", 0, {26'd0, busy, done}, 0);
        reset = 1'b1;
        @(negedge clk);

        // Run 1: start held through early SHIFT, pattern changed after acceptance.
        pattern = P1; pattern_c = P2; start = 1'b1;
        @(negedge clk);
        pattern = 16'hA5A5; pattern_c = 16'h0000;
        repeat (5) @(negedge clk);
        check("busy_held_start", 0, {29'd0, busy}, 7);
        start = 1'b0;
        repeat (14) @(negedge clk);
        check("done_a_e19", 0, {31'd0, done[0]}, 0);
        @(negedge clk);
        check("done_a_e20", 0, {31'd0, done[0]}, 1);
        check("count_a", 0, cnt_of(0), 3);
        check("model_cnt_a", 0, mcnt[0], 3);
        check("det_w_seq_a", 0, {16'd0, cap_a}, {16'd0, P1});
        check("done_c", 2, {31'd0, done[2]}, 1);
        check("count_c_sat", 2, cnt_of(2), 3);
        repeat (31) @(negedge clk);
        check("done_b_e51", 1, {31'd0, done[1]}, 0);
        @(negedge clk);
        check("done_b_e52", 1, {31'd0, done[1]}, 1);
        check("count_b", 1, cnt_of(1), 3);

        // Run 2: restart from DONE with an all-zero word.
        pattern = 16'h0000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("count_cleared", 0, cnt_of(0), 0);
        repeat (19) @(negedge clk);
        check("done_a_r2_e19", 0, {31'd0, done[0]}, 0);
        @(negedge clk);
        check("done_a_r2_e20", 0, {31'd0, done[0]}, 1);
        check("count_a_r2", 0, cnt_of(0), 0);
        repeat (32) @(negedge clk);
        check("done_b_r2", 1, {31'd0, done[1]}, 1);

        // Run 3: reset mid-SHIFT.
        pattern = P1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        check("busy_mid_shift", 0, {29'd0, busy}, 7);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        check("rr_det_rst", 0, {29'd0, det_rst}, 7);
        check("rr_det_w", 0, {29'd0, det_w}, 0);
        check("rr_busy", 0, {29'd0, busy}, 0);
        check("rr_done", 0, {29'd0, done}, 0);
        check("rr_count_a", 0, cnt_of(0), 0);
        repeat (4) @(negedge clk);
        check("idle_stays", 0, {29'd0, busy}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
